// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and next-PC selector for
// the instruction-fetch stage.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned PC_INCR_DEFAULT = 4;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_SEQ      = 2'd1,
    PC_REDIRECT = 2'd2,
    PC_SAVED    = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface fetch_stage_if;
  import cpu_types_pkg::*;

  // imemREN requests the word at imemaddr; imemload is valid only in a cycle
  // with ihit=1, and the requester keeps imemaddr stable until that cycle.
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;

  modport master (
    output imemREN,
    output imemaddr,
    input  ihit,
    input  imemload
  );

  modport slave (
    input  imemREN,
    input  imemaddr,
    output ihit,
    output imemload
  );

endinterface

// File: rtl/fetch_stage_pc_unit.sv
// PC and saved-redirect-target registers with the next-PC mux.
module pc_unit
  import cpu_types_pkg::*;
#(
  parameter word_t       PC_INIT = 32'h0000_0000,
  parameter int unsigned PC_INCR = PC_INCR_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  input  pc_sel_t pc_sel,
  input  logic    save_target,
  input  word_t   redirect_target,
  output word_t   pc,
  output word_t   pc_plus_incr
);

  word_t pc_q, pc_d;
  word_t saved_target_q, saved_target_d;

  // Modulo 2^32: the top word address wraps to zero.
  assign pc_plus_incr = pc_q + word_t'(PC_INCR);
  assign pc           = pc_q;

  always_comb begin
    pc_d           = pc_q;
    saved_target_d = saved_target_q;
    if (save_target) begin
      saved_target_d = redirect_target;
    end
    case (pc_sel)
      PC_HOLD:     pc_d = pc_q;
      PC_SEQ:      pc_d = pc_plus_incr;
      PC_REDIRECT: pc_d = redirect_target;
      PC_SAVED:    pc_d = saved_target_q;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= PC_INIT;
      saved_target_q <= '0;
    end else begin
      pc_q           <= pc_d;
      saved_target_q <= saved_target_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: FETCH/DRAIN/HALTED control and IF/ID write/flush.
// Optional FETCH_STATS_EN adds saturating fetched/squashed counters.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t       PC_INIT = 32'h0000_0000,
  parameter int unsigned PC_INCR = PC_INCR_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  fetch_stage_if.master imem,
  input  logic          stall,
  input  logic          redirect,
  input  word_t         redirect_target,
  input  logic          halt_dec,
  output word_t         instruction_out,
  output word_t         next_address_out,
  output logic          ifid_wen,
  output logic          ifid_flush,
  output logic          fetch_halted,
`ifdef FETCH_STATS_EN
  output word_t         stat_fetched,
  output word_t         stat_squashed,
`endif
  output fetch_state_t  state_dbg
);

  fetch_state_t state_q, state_d;
  pc_sel_t      pc_sel;
  logic         save_target;
  logic         redirect_accepted;
  word_t        pc;
  word_t        pc_plus_incr;

  pc_unit #(
    .PC_INIT (PC_INIT),
    .PC_INCR (PC_INCR)
  ) u_pc_unit (
    .clk             (CLK),
    .rst             (RST),
    .pc_sel          (pc_sel),
    .save_target     (save_target),
    .redirect_target (redirect_target),
    .pc              (pc),
    .pc_plus_incr    (pc_plus_incr)
  );

  always_comb begin
    state_d           = state_q;
    pc_sel            = PC_HOLD;
    save_target       = 1'b0;
    redirect_accepted = 1'b0;
    imem.imemREN      = 1'b1;
    ifid_wen          = 1'b1;
    ifid_flush        = 1'b1;

    case (state_q)
      FETCH: begin
        if (redirect) begin
          redirect_accepted = 1'b1;
          if (imem.ihit) begin
            pc_sel = PC_REDIRECT;
          end else begin
            // Miss outstanding: keep the address, park the target until it lands.
            save_target = 1'b1;
            state_d     = DRAIN;
          end
        end else if (stall) begin
          ifid_wen   = 1'b0;
          ifid_flush = 1'b0;
        end else if (halt_dec) begin
          state_d = HALTED;
        end else if (imem.ihit) begin
          pc_sel     = PC_SEQ;
          ifid_flush = 1'b0;
        end
      end

      DRAIN: begin
        if (redirect) begin
          redirect_accepted = 1'b1;
          save_target       = 1'b1;
        end
        if (imem.ihit) begin
          pc_sel  = redirect ? PC_REDIRECT : PC_SAVED;
          state_d = FETCH;
        end
      end

      HALTED: begin
        imem.imemREN = 1'b0;
        ifid_wen     = 1'b0;
        ifid_flush   = 1'b0;
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    // IF/ID sees a bubble and memory sees no request while reset is held.
    if (RST) begin
      imem.imemREN      = 1'b0;
      ifid_wen          = 1'b0;
      ifid_flush        = 1'b1;
      redirect_accepted = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign imem.imemaddr    = pc;
  assign instruction_out  = imem.imemload;
  assign next_address_out = pc_plus_incr;
  assign fetch_halted     = (state_q == HALTED);
  assign state_dbg        = state_q;

`ifdef FETCH_STATS_EN
  word_t stat_fetched_q, stat_fetched_d;
  word_t stat_squashed_q, stat_squashed_d;
  logic  fetched_evt;

  assign fetched_evt = (state_q == FETCH) && imem.ihit && ifid_wen && !ifid_flush;

  always_comb begin
    stat_fetched_d  = stat_fetched_q;
    stat_squashed_d = stat_squashed_q;
    if (fetched_evt && (stat_fetched_q != 32'hFFFF_FFFF)) begin
      stat_fetched_d = stat_fetched_q + 32'd1;
    end
    if (redirect_accepted && (stat_squashed_q != 32'hFFFF_FFFF)) begin
      stat_squashed_d = stat_squashed_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_fetched_q  <= '0;
      stat_squashed_q <= '0;
    end else begin
      stat_fetched_q  <= stat_fetched_d;
      stat_squashed_q <= stat_squashed_d;
    end
  end

  assign stat_fetched  = stat_fetched_q;
  assign stat_squashed = stat_squashed_q;
`else
  logic unused_redirect_accepted;
  assign unused_redirect_accepted = redirect_accepted;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle expectations queued by the driver,
// compared by an independent monitor on the falling edge.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  // {imemREN, imemaddr, next_address_out, instruction_out, ifid_wen, ifid_flush, fetch_halted}
  localparam int EW = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         stall;
  logic         redirect;
  word_t        redirect_target;
  logic         halt_dec;
  word_t        instruction_out;
  word_t        next_address_out;
  logic         ifid_wen;
  logic         ifid_flush;
  logic         fetch_halted;
  fetch_state_t state_dbg;
`ifdef FETCH_STATS_EN
  word_t        stat_fetched;
  word_t        stat_squashed;
`endif

  fetch_stage_if imem_if ();

  fetch_stage dut (
    .CLK              (clk),
    .RST              (rst),
    .imem             (imem_if),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .halt_dec         (halt_dec),
    .instruction_out  (instruction_out),
    .next_address_out (next_address_out),
    .ifid_wen         (ifid_wen),
    .ifid_flush       (ifid_flush),
    .fetch_halted     (fetch_halted),
`ifdef FETCH_STATS_EN
    .stat_fetched     (stat_fetched),
    .stat_squashed    (stat_squashed),
`endif
    .state_dbg        (state_dbg)
  );

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int vec_n    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, vec_n, act, exp);
    end
  endtask

  // One cycle of stimulus plus the outputs expected while it is applied.
  task automatic cyc(input logic r, input logic h, input logic s, input logic rd,
                     input logic hd, input word_t tgt, input word_t e_addr,
                     input logic e_ren, input logic e_wen, input logic e_fl,
                     input logic e_hlt);
    word_t load;
    @(posedge clk);
    #1;
    load                     = 32'hC0DE_0000 ^ word_t'(vec_n);
    rst                      = r;
    imem_if.ihit             = h;
    imem_if.imemload         = load;
    stall                    = s;
    redirect                 = rd;
    redirect_target          = tgt;
    halt_dec                 = hd;
    exp_q.push_back({e_ren, e_addr, e_addr + 32'd4, load, e_wen, e_fl, e_hlt});
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("imemREN",          {31'd0, imem_if.imemREN}, {31'd0, e[99]});
      chk("imemaddr",         imem_if.imemaddr,         e[98:67]);
      chk("next_address_out", next_address_out,         e[66:35]);
      chk("instruction_out",  instruction_out,          e[34:3]);
      chk("ifid_wen",         {31'd0, ifid_wen},        {31'd0, e[2]});
      chk("ifid_flush",       {31'd0, ifid_flush},      {31'd0, e[1]});
      chk("fetch_halted",     {31'd0, fetch_halted},    {31'd0, e[0]});
      vec_n++;
    end
  end

  initial begin
    rst              = 1'b1;
    stall            = 1'b0;
    redirect         = 1'b0;
    redirect_target  = '0;
    halt_dec         = 1'b0;
    imem_if.ihit     = 1'b0;
    imem_if.imemload = '0;
    @(posedge clk);

    //  rst ihit stall redir halt target         addr          ren wen fl hlt
    cyc(1, 0, 0, 0, 0, 32'h0,          32'h0,          0, 0, 1, 0);
    // sequential fetch
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h0,          1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h4,          1, 1, 0, 0);
    // three-cycle miss at 8
    cyc(0, 0, 0, 0, 0, 32'h0,          32'h8,          1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 32'h0,          32'h8,          1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 32'h0,          32'h8,          1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h8,          1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'hC,          1, 1, 0, 0);
    // stall at 10
    cyc(0, 1, 1, 0, 0, 32'h0,          32'h10,         1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 32'h0,          32'h10,         1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h10,         1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h14,         1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h18,         1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h1C,         1, 1, 0, 0);
    // redirect with hit
    cyc(0, 1, 0, 1, 0, 32'h100,        32'h20,         1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h100,        1, 1, 0, 0);
    // redirect on miss: drain, stall/halt ignored
    cyc(0, 0, 0, 1, 0, 32'h200,        32'h104,        1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 32'h0,          32'h104,        1, 1, 1, 0);
    cyc(0, 0, 1, 0, 1, 32'h0,          32'h104,        1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h104,        1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h200,        1, 1, 0, 0);
    // second redirect while draining overwrites the target
    cyc(0, 0, 0, 1, 0, 32'h250,        32'h204,        1, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 32'h300,        32'h204,        1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h204,        1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h300,        1, 1, 0, 0);
    // redirect coinciding with ihit in DRAIN
    cyc(0, 0, 0, 1, 0, 32'h400,        32'h304,        1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0, 32'h500,        32'h304,        1, 1, 1, 0);
    // redirect beats stall and halt
    cyc(0, 1, 1, 1, 1, 32'h600,        32'h500,        1, 1, 1, 0);
    // halt, then frozen
    cyc(0, 1, 0, 0, 1, 32'h0,          32'h600,        1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0, 32'h700,        32'h600,        0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1, 32'h0,          32'h600,        0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 32'h0,          32'h600,        0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h0,          1, 1, 0, 0);
    // wrap at top of address space
    cyc(0, 1, 0, 1, 0, 32'hFFFF_FFFC,  32'h4,          1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'hFFFF_FFFC,  1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h0,          1, 1, 0, 0);
    // reset in DRAIN discards the parked target
    cyc(0, 0, 0, 1, 0, 32'h80,         32'h4,          1, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 32'h0,          32'h4,          0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h0,          1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 32'h0,          32'h4,          1, 1, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
